// File: rtl/lfgm_gen_ln_p.sv
// rtl/lfgm_gen_ln_p.sv - Life next-generation line generator with rule masks, wrap, LFSR regen and popcount
module lfgm_gen_ln_p #(
    parameter int unsigned GP_CELL_W    = 80,
    parameter int unsigned GP_ROWS      = 60,
    parameter bit          GP_HWRAP     = 1'b0,
    parameter logic [15:0] GP_LFSR_SEED = 16'd3568
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 frm_start,
    input  logic [8:0]                           birth_mask,
    input  logic [8:0]                           surv_mask,
    input  logic                                 rgen_en,
    input  logic                                 in_vld,
    output logic                                 in_rdy,
    input  logic [GP_CELL_W-1:0]                 in_data,
    output logic                                 out_vld,
    input  logic                                 out_rdy,
    output logic [GP_CELL_W-1:0]                 out_data,
    output logic [$clog2(GP_CELL_W+1)-1:0]       out_pop,
    output logic                                 out_last,
    output logic                                 frm_done,
    output logic                                 busy
);
    localparam int unsigned POP_W = $clog2(GP_CELL_W + 1);
    localparam int unsigned CNT_W = $clog2(GP_ROWS + 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(GP_ROWS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]           state;
    logic [8:0]           birth_q, surv_q;
    logic [GP_CELL_W-1:0] prev, cur, rng;
    logic [CNT_W-1:0]     in_cnt;
    logic [15:0]          lfsr, lfsr_nxt;
    logic [GP_CELL_W-1:0] dn_line, rule_line, line_out;
    logic [POP_W-1:0]     pop_out;
    logic                 out_free;

    // Edge columns are padded with either zero or the opposite edge cell
    function automatic logic [GP_CELL_W-1:0] life_line(
        input logic [GP_CELL_W-1:0] up,
        input logic [GP_CELL_W-1:0] mid,
        input logic [GP_CELL_W-1:0] dn,
        input logic [8:0]           bm,
        input logic [8:0]           sm
    );
        logic [GP_CELL_W+1:0] eu, em, ed;
        logic [3:0]           n;
        life_line = '0;
        eu = {GP_HWRAP ? up[0]  : 1'b0, up,  GP_HWRAP ? up[GP_CELL_W-1]  : 1'b0};
        em = {GP_HWRAP ? mid[0] : 1'b0, mid, GP_HWRAP ? mid[GP_CELL_W-1] : 1'b0};
        ed = {GP_HWRAP ? dn[0]  : 1'b0, dn,  GP_HWRAP ? dn[GP_CELL_W-1]  : 1'b0};
        for (int i = 0; i < GP_CELL_W; i++) begin
            n = 4'(eu[i]) + 4'(eu[i+1]) + 4'(eu[i+2])
              + 4'(em[i])               + 4'(em[i+2])
              + 4'(ed[i]) + 4'(ed[i+1]) + 4'(ed[i+2]);
            life_line[i] = em[i+1] ? sm[n] : bm[n];
        end
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [GP_CELL_W-1:0] v);
        popcount = '0;
        for (int i = 0; i < GP_CELL_W; i++) begin
            popcount = popcount + POP_W'(v[i]);
        end
    endfunction

    always_comb begin
        out_free  = ~out_vld | out_rdy;
        dn_line   = (state == ST_FLUSH) ? '0 : in_data;
        rule_line = life_line(prev, cur, dn_line, birth_q, surv_q);
        line_out  = rule_line ^ (rgen_en ? rng : '0);
        pop_out   = popcount(line_out);
        lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        busy      = (state != ST_IDLE);
        case (state)
            ST_FILL: in_rdy = 1'b1;
            ST_RUN:  in_rdy = out_free;
            default: in_rdy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            birth_q  <= '0;
            surv_q   <= '0;
            prev     <= '0;
            cur      <= '0;
            in_cnt   <= '0;
            rng      <= '0;
            lfsr     <= GP_LFSR_SEED;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_pop  <= '0;
            out_last <= 1'b0;
            frm_done <= 1'b0;
        end else begin
            lfsr     <= lfsr_nxt;
            rng      <= {rng[GP_CELL_W-2:0], lfsr[15]};
            frm_done <= 1'b0;
            // frm_start wins in every state; mid-frame it discards the partial frame silently
            if (frm_start) begin
                birth_q  <= birth_mask;
                surv_q   <= surv_mask;
                prev     <= '0;
                cur      <= '0;
                in_cnt   <= '0;
                out_vld  <= 1'b0;
                out_last <= 1'b0;
                state    <= ST_FILL;
            end else begin
                case (state)
                    ST_FILL: begin
                        if (in_vld) begin
                            cur    <= in_data;
                            in_cnt <= CNT_W'(1);
                            state  <= (GP_ROWS == 1) ? ST_FLUSH : ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (in_vld && in_rdy) begin
                            out_data <= line_out;
                            out_pop  <= pop_out;
                            out_vld  <= 1'b1;
                            prev     <= cur;
                            cur      <= in_data;
                            in_cnt   <= in_cnt + 1'b1;
                            if (in_cnt == LAST_ROW) state <= ST_FLUSH;
                        end else if (out_rdy) begin
                            out_vld <= 1'b0;
                        end
                    end
                    ST_FLUSH: begin
                        if (out_free) begin
                            out_data <= line_out;
                            out_pop  <= pop_out;
                            out_vld  <= 1'b1;
                            out_last <= 1'b1;
                            state    <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (out_rdy) begin
                            out_vld  <= 1'b0;
                            out_last <= 1'b0;
                            frm_done <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lfgm_gen_ln_p.sv
// tb/tb_lfgm_gen_ln_p.sv - directed bench for lfgm_gen_ln_p, W=8 ROWS=4, wall and wrap instances
module tb_lfgm_gen_ln_p;
    localparam logic [15:0] SEED = 16'd3568;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frm_start = 1'b0;
    logic [8:0] birth_mask = '0, surv_mask = '0;
    logic       rgen_en = 1'b0;
    logic       in_vld = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_rdy = 1'b0;

    logic       w_in_rdy, w_out_vld, w_out_last, w_frm_done, w_busy;
    logic [7:0] w_out_data;
    logic [3:0] w_out_pop;
    logic       r_in_rdy, r_out_vld, r_out_last, r_frm_done, r_busy;
    logic [7:0] r_out_data;
    logic [3:0] r_out_pop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfgm_gen_ln_p #(.GP_CELL_W(8), .GP_ROWS(4), .GP_HWRAP(1'b0), .GP_LFSR_SEED(SEED)) u_wall (
        .clk(clk), .rst_n(rst_n), .frm_start(frm_start), .birth_mask(birth_mask), .surv_mask(surv_mask),
        .rgen_en(rgen_en), .in_vld(in_vld), .in_rdy(w_in_rdy), .in_data(in_data), .out_vld(w_out_vld),
        .out_rdy(out_rdy), .out_data(w_out_data), .out_pop(w_out_pop), .out_last(w_out_last),
        .frm_done(w_frm_done), .busy(w_busy));

    lfgm_gen_ln_p #(.GP_CELL_W(8), .GP_ROWS(4), .GP_HWRAP(1'b1), .GP_LFSR_SEED(SEED)) u_wrap (
        .clk(clk), .rst_n(rst_n), .frm_start(frm_start), .birth_mask(birth_mask), .surv_mask(surv_mask),
        .rgen_en(rgen_en), .in_vld(in_vld), .in_rdy(r_in_rdy), .in_data(in_data), .out_vld(r_out_vld),
        .out_rdy(out_rdy), .out_data(r_out_data), .out_pop(r_out_pop), .out_last(r_out_last),
        .frm_done(r_frm_done), .busy(r_busy));

    // Reference Galois LFSR (x^16+x^14+x^13+x^11+1) and rng line; m_rng_prev is the line before the last edge
    logic [15:0] m_lfsr;
    logic [7:0]  m_rng, m_rng_prev;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_lfsr <= SEED;
            m_rng  <= '0;
        end else begin
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            m_rng  <= {m_rng[6:0], m_lfsr[15]};
        end
        m_rng_prev <= m_rng;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [8:0] b, input logic [8:0] s, input logic rg);
        @(negedge clk);
        in_vld     = 1'b0;
        frm_start  = 1'b1;
        birth_mask = b;
        surv_mask  = s;
        rgen_en    = rg;
        @(posedge clk);
        #1;
        frm_start  = 1'b0;
        birth_mask = '0;
        surv_mask  = '0;
    endtask

    // rows/exp packed with row 0 in [7:0]; stall bit c holds out_rdy low in loop cycle c
    task automatic run_frame(input string tag, input logic [8:0] b, input logic [8:0] s, input logic rg,
                             input logic [31:0] rows, input logic [31:0] exp_wall,
                             input logic [31:0] exp_wrap, input logic [31:0] stall);
        int k = 0, n = 0, cyc = 0, last_cyc = 0, done_cnt = 0;
        logic prev_vld = 1'b0, prev_rdy = 1'b0;
        logic [7:0] held = '0, rng_now = '0, ew, er;
        start_frame(b, s, rg);
        while (cyc < 40 && !(n == 4 && cyc > last_cyc + 2)) begin
            @(negedge clk);
            out_rdy = ~stall[cyc % 32];
            in_vld  = (k < 4);
            in_data = (k < 4) ? rows[k*8 +: 8] : 8'h00;
            #1;
            if (w_frm_done) begin
                done_cnt++;
                chk({tag, " done_cycle"}, cyc, last_cyc + 1);
            end
            if (w_out_vld) begin
                if (prev_vld && !prev_rdy)
                    chk({tag, " hold"}, w_out_data, held);
                else
                    rng_now = rg ? m_rng_prev : 8'h00;
                if (!out_rdy) chk({tag, " in_rdy_stall"}, w_in_rdy, 0);
                if (out_rdy && n < 4) begin
                    ew = exp_wall[n*8 +: 8] ^ rng_now;
                    er = exp_wrap[n*8 +: 8] ^ rng_now;
                    chk({tag, " wall_data"}, w_out_data, ew);
                    chk({tag, " wall_pop"}, w_out_pop, $countones(ew));
                    chk({tag, " wrap_data"}, r_out_data, er);
                    chk({tag, " wrap_pop"}, r_out_pop, $countones(er));
                    chk({tag, " last"}, w_out_last, (n == 3));
                    n++;
                    last_cyc = cyc;
                end else if (out_rdy) begin
                    chk({tag, " extra_line"}, n, 4);
                end
            end
            prev_vld = w_out_vld;
            prev_rdy = out_rdy;
            held     = w_out_data;
            if (in_vld && w_in_rdy) k++;
            cyc++;
        end
        chk({tag, " lines"}, n, 4);
        chk({tag, " accepted"}, k, 4);
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " idle"}, w_busy, 0);
        in_vld  = 1'b0;
        out_rdy = 1'b0;
    endtask

    task automatic feed(input string tag, input int cnt, input logic [31:0] rows);
        int k = 0, cyc = 0;
        while (k < cnt && cyc < 20) begin
            @(negedge clk);
            out_rdy = 1'b1;
            in_vld  = 1'b1;
            in_data = rows[k*8 +: 8];
            #1;
            if (w_in_rdy) k++;
            cyc++;
        end
        chk({tag, " fed"}, k, cnt);
    endtask

    initial begin
        int dones;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst in_rdy", w_in_rdy, 0);
        chk("rst out_vld", w_out_vld, 0);
        chk("rst out_data", w_out_data, 0);
        chk("rst out_pop", w_out_pop, 0);
        chk("rst out_last", w_out_last, 0);
        chk("rst frm_done", w_frm_done, 0);
        chk("rst busy", w_busy, 0);
        rst_n = 1'b1;

        run_frame("blinker", 9'h008, 9'h00C, 1'b0, 32'h0000_1C00, 32'h0008_0808, 32'h0008_0808, 32'h0);
        run_frame("edge83", 9'h008, 9'h00C, 1'b0, 32'h0000_8300, 32'h0000_0000, 32'h0001_0101, 32'h0);
        run_frame("hl_zero", 9'h048, 9'h00C, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0);
        run_frame("hl_block", 9'h048, 9'h00C, 1'b0, 32'h0018_1800, 32'h0018_1800, 32'h0018_1800, 32'h0);
        run_frame("bp", 9'h008, 9'h00C, 1'b0, 32'h0000_1C00, 32'h0008_0808, 32'h0008_0808, 32'h0000_007C);
        run_frame("rgen", 9'h008, 9'h00C, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0);

        // abort after row 2 is accepted
        start_frame(9'h008, 9'h00C, 1'b0);
        feed("abort", 3, 32'h0000_1C00);
        @(negedge clk);
        in_vld = 1'b0;
        #1;
        chk("abort pre_vld", w_out_vld, 1);
        frm_start  = 1'b1;
        birth_mask = 9'h008;
        surv_mask  = 9'h00C;
        @(negedge clk);
        frm_start = 1'b0;
        #1;
        chk("abort out_vld", w_out_vld, 0);
        chk("abort in_rdy", w_in_rdy, 1);
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (w_frm_done) dones++;
        end
        chk("abort no_done", dones, 0);
        run_frame("post_abort", 9'h008, 9'h00C, 1'b0, 32'h0000_1C00, 32'h0008_0808, 32'h0008_0808, 32'h0);

        // reset mid-RUN
        start_frame(9'h008, 9'h00C, 1'b0);
        feed("midrst", 2, 32'h0000_1C00);
        @(negedge clk);
        in_vld = 1'b0;
        #1;
        chk("midrst pre_vld", w_out_vld, 1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst in_rdy", w_in_rdy, 0);
        chk("midrst out_vld", w_out_vld, 0);
        chk("midrst out_data", w_out_data, 0);
        chk("midrst out_pop", w_out_pop, 0);
        chk("midrst out_last", w_out_last, 0);
        chk("midrst frm_done", w_frm_done, 0);
        chk("midrst busy", w_busy, 0);
        rst_n = 1'b1;
        run_frame("post_rst", 9'h008, 9'h00C, 1'b0, 32'h0000_8300, 32'h0000_0000, 32'h0001_0101, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
